rf_writeback_queue: RTL and testbench

- Write-side front end of the register file. Collects results from NUM_SRC execution units over valid/ready handshakes.
- Arbitrates round-robin, accepting at most one result per cycle, and buffers results in order in a DEPTH-entry FIFO.
- Drives the register file's single write port from the FIFO head.
- Exports a per-register pending mask so issue logic can stall on registers with queued writes.

---
 rtl/rf_writeback_queue.sv | 122 ++++++++++++
 tb/tb_rf_writeback_queue.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_queue.sv
// Register-file write front end: round-robin accepts results from NUM_SRC producers,
// queues them in an in-order FIFO, drains through the single write port, tracks pending regs.
module rf_writeback_queue #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_SRC-1:0]                   src_valid,
  output logic [NUM_SRC-1:0]                   src_ready,
  input  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0]   src_addr,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]   src_data,
  input  logic                                 rf_stall,
  output logic                                 rf_write_enable,
  output logic [ADDR_WIDTH-1:0]                rf_write_addr,
  output logic [DATA_WIDTH-1:0]                rf_write_data,
  output logic [NUM_REGS-1:0]                  pending_mask,
  output logic [$clog2(DEPTH):0]               count,
  output logic                                 full,
  output logic                                 empty
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW:0]           r_count;
  logic [SW-1:0]         r_rr_ptr;
  logic [DEPTH-1:0]      r_valid;
  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];

  logic                  w_pop;
  logic                  w_space;
  logic                  w_found;
  logic                  w_xfer;
  logic                  w_push;
  logic [SW-1:0]         w_grant;
  logic [SW-1:0]         w_rr_next;
  logic [ADDR_WIDTH-1:0] w_push_addr;
  logic [DATA_WIDTH-1:0] w_push_data;

  assign empty           = (r_count == '0);
  assign full            = (r_count == (PW+1)'(DEPTH));
  assign count           = r_count;
  assign w_pop           = !empty && !rf_stall;
  assign rf_write_enable = w_pop;
  assign rf_write_addr   = empty ? '0 : r_addr[r_rd_ptr];
  assign rf_write_data   = empty ? '0 : r_data[r_rd_ptr];
  assign w_space         = !full || w_pop;

  // Two passes: indices at or above rr_ptr first, then the wrapped-around low indices.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!w_found && (i >= 32'(r_rr_ptr)) && src_valid[i]) begin
        w_found = 1'b1;
        w_grant = SW'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!w_found && src_valid[i]) begin
        w_found = 1'b1;
        w_grant = SW'(i);
      end
    end
  end

  assign w_rr_next   = (32'(w_grant) == NUM_SRC - 1) ? '0 : w_grant + 1'b1;
  assign w_xfer      = w_found && w_space && !rst;
  assign w_push_addr = src_addr[w_grant];
  assign w_push_data = src_data[w_grant];
  // Register 0 is hardwired: handshake completes but nothing is queued.
  assign w_push      = w_xfer && (w_push_addr != '0);

  always_comb begin
    src_ready = '0;
    if (w_xfer) src_ready[w_grant] = 1'b1;
  end

  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_valid[i]) pending_mask[r_addr[i]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_rr_ptr <= '0;
      r_valid  <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr          <= r_rd_ptr + 1'b1;
        r_valid[r_rd_ptr] <= 1'b0;
      end
      // Set after clear so a push into the slot being popped (full FIFO) stays valid.
      if (w_push) begin
        r_wr_ptr          <= r_wr_ptr + 1'b1;
        r_valid[r_wr_ptr] <= 1'b1;
      end
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      if (w_xfer) r_rr_ptr <= w_rr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= w_push_addr;
      r_data[r_wr_ptr] <= w_push_data;
    end
  end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Scenario-task bench for rf_writeback_queue; a negedge monitor scoreboards every write-port
// transaction, pending mask and count against the queue of accepted nonzero-address results.
module tb_rf_writeback_queue;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int NS = 2;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NS-1:0]          src_valid = '0;
  logic [NS-1:0]          src_ready;
  logic [NS-1:0][AW-1:0]  src_addr = '0;
  logic [NS-1:0][DW-1:0]  src_data = '0;
  logic                   rf_stall = 1'b0;
  logic                   rf_write_enable;
  logic [AW-1:0]          rf_write_addr;
  logic [DW-1:0]          rf_write_data;
  logic [NR-1:0]          pending_mask;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   exp_rr = 0;

  rf_writeback_queue #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .NUM_SRC(NS), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(src_ready),
    .src_addr(src_addr), .src_data(src_data), .rf_stall(rf_stall),
    .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .pending_mask(pending_mask), .count(count),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Scoreboard: sampled mid-low-phase, reflecting what the next rising edge will commit.
  always @(negedge clk) begin
    logic [NR-1:0] m;
    ent_t e;
    #2;
    if (!rst) begin
      m = '0;
      foreach (sb[i]) m[sb[i].a] = 1'b1;
      m[0] = 1'b0;
      total++;
      if (pending_mask !== m) begin
        bad++;
        $display("FAIL sb_pending got=%h exp=%h t=%0t", pending_mask, m, $time);
      end
      total++;
      if (count !== 3'(sb.size())) begin
        bad++;
        $display("FAIL sb_count got=%0d exp=%0d t=%0t", count, sb.size(), $time);
      end
      if (rf_write_enable === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_write got=%0h/%h exp=none t=%0t",
                   rf_write_addr, rf_write_data, $time);
        end else begin
          e = sb.pop_front();
          if (rf_write_addr !== e.a || rf_write_data !== e.d) begin
            bad++;
            $display("FAIL sb_write got=%0h/%h exp=%0h/%h t=%0t",
                     rf_write_addr, rf_write_data, e.a, e.d, $time);
          end
        end
      end
      for (int s = 0; s < NS; s++) begin
        if (src_valid[s] && src_ready[s] && src_addr[s] != '0) begin
          e.a = src_addr[s];
          e.d = src_data[s];
          sb.push_back(e);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    src_valid = 2'b11;
    src_addr[0] = 5'd1;
    src_addr[1] = 5'd2;
    repeat (2) @(negedge clk);
    #1;
    total++; if (src_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", src_ready); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (rf_write_enable !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", rf_write_enable); end
    total++; if (pending_mask !== '0) begin bad++; $display("FAIL reset_pending got=%h exp=0", pending_mask); end
    total++; if (rf_write_addr !== '0 || rf_write_data !== '0) begin
      bad++; $display("FAIL reset_port got=%0h/%h exp=0/0", rf_write_addr, rf_write_data);
    end
    src_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    exp_rr = 0;
  endtask

  task automatic test_single();
    @(negedge clk);
    src_valid = 2'b01;
    src_addr[0] = 5'd5;
    src_data[0] = 32'hDEADBEEF;
    #1;
    total++; if (src_ready !== 2'b01) begin bad++; $display("FAIL single_ready got=%b exp=01", src_ready); end
    exp_rr = 1;
    @(negedge clk);
    src_valid = '0;
    #1;
    total++; if (rf_write_enable !== 1'b1) begin bad++; $display("FAIL single_we got=%b exp=1", rf_write_enable); end
    total++; if (rf_write_addr !== 5'd5 || rf_write_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL single_port got=%0h/%h exp=5/deadbeef", rf_write_addr, rf_write_data);
    end
    total++; if (pending_mask !== 32'h20) begin bad++; $display("FAIL single_pending got=%h exp=20", pending_mask); end
    @(negedge clk);
    #1;
    total++; if (empty !== 1'b1 || pending_mask !== '0) begin
      bad++; $display("FAIL single_drained got=%b/%h exp=1/0", empty, pending_mask);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      src_valid = 2'b11;
      src_addr[0] = 5'd1;
      src_addr[1] = 5'd2;
      src_data[0] = 32'h1000 + i;
      src_data[1] = 32'h2000 + i;
      #1;
      total++; if (src_ready !== 2'(1 << exp_rr)) begin
        bad++; $display("FAIL b2b_grant got=%b exp=%b", src_ready, 2'(1 << exp_rr));
      end
      total++; if (count > 1) begin bad++; $display("FAIL b2b_count got=%0d exp<=1", count); end
      exp_rr = exp_rr ^ 1;
    end
    @(negedge clk);
    src_valid = '0;
    @(negedge clk);
    #1;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_drained got=%b exp=1", empty); end
  endtask

  task automatic test_full();
    rf_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      src_valid = 2'b01;
      src_addr[0] = 5'(3 + i);
      src_data[0] = 32'hA0 + i;
      #1;
      total++; if (src_ready !== 2'b01) begin bad++; $display("FAIL full_push%0d got=%b exp=01", i, src_ready); end
    end
    exp_rr = 1;
    @(negedge clk);
    src_addr[0] = 5'd7;
    src_data[0] = 32'hA7;
    #1;
    total++; if (full !== 1'b1 || count !== 3'd4) begin
      bad++; $display("FAIL full_flag got=%b/%0d exp=1/4", full, count);
    end
    total++; if (src_ready !== 2'b00) begin bad++; $display("FAIL full_blocked got=%b exp=00", src_ready); end
    total++; if (pending_mask !== 32'h78) begin bad++; $display("FAIL full_pending got=%h exp=78", pending_mask); end
    total++; if (rf_write_enable !== 1'b0) begin bad++; $display("FAIL full_stalled got=%b exp=0", rf_write_enable); end
    @(negedge clk);
    rf_stall = 1'b0;
    #1;
    total++; if (rf_write_enable !== 1'b1 || rf_write_addr !== 5'd3) begin
      bad++; $display("FAIL full_drain got=%b/%0h exp=1/3", rf_write_enable, rf_write_addr);
    end
    total++; if (src_ready !== 2'b01) begin bad++; $display("FAIL full_push_on_pop got=%b exp=01", src_ready); end
    @(negedge clk);
    src_valid = '0;
    repeat (4) @(negedge clk);
    #1;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL full_drained got=%b exp=1", empty); end
  endtask

  task automatic test_reg0();
    @(negedge clk);
    src_valid = 2'b10;
    src_addr[1] = 5'd0;
    src_data[1] = 32'h55;
    #1;
    total++; if (src_ready !== 2'b10) begin bad++; $display("FAIL reg0_ready got=%b exp=10", src_ready); end
    exp_rr = 0;
    @(negedge clk);
    src_valid = '0;
    #1;
    total++; if (count !== 3'd0 || rf_write_enable !== 1'b0) begin
      bad++; $display("FAIL reg0_dropped got=%0d/%b exp=0/0", count, rf_write_enable);
    end
    @(negedge clk);
    src_valid = 2'b11;
    src_addr[0] = 5'd9;
    src_addr[1] = 5'd10;
    #1;
    total++; if (src_ready !== 2'(1 << exp_rr)) begin
      bad++; $display("FAIL reg0_rr got=%b exp=%b", src_ready, 2'(1 << exp_rr));
    end
    src_valid = '0;
  endtask

  task automatic test_reset_mid();
    rf_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      src_valid = 2'b01;
      src_addr[0] = 5'(8 + i);
      src_data[0] = 32'hB0 + i;
    end
    @(negedge clk);
    src_valid = '0;
    #1;
    total++; if (count !== 3'd3) begin bad++; $display("FAIL rstmid_pre got=%0d exp=3", count); end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++; if (count !== 3'd0 || empty !== 1'b1) begin
      bad++; $display("FAIL rstmid_count got=%0d/%b exp=0/1", count, empty);
    end
    total++; if (pending_mask !== '0 || rf_write_enable !== 1'b0) begin
      bad++; $display("FAIL rstmid_out got=%h/%b exp=0/0", pending_mask, rf_write_enable);
    end
    sb.delete();
    exp_rr = 0;
    @(negedge clk);
    rst = 1'b0;
    rf_stall = 1'b0;
    @(negedge clk);
    src_valid = 2'b01;
    src_addr[0] = 5'd7;
    src_data[0] = 32'h77;
    #1;
    total++; if (src_ready !== 2'b01) begin bad++; $display("FAIL rstmid_ready got=%b exp=01", src_ready); end
    @(negedge clk);
    src_valid = '0;
    #1;
    total++; if (rf_write_enable !== 1'b1 || rf_write_addr !== 5'd7 || rf_write_data !== 32'h77) begin
      bad++; $display("FAIL rstmid_write got=%b/%0h/%h exp=1/7/77", rf_write_enable, rf_write_addr, rf_write_data);
    end
    total++; if (count !== 3'd1 || pending_mask !== 32'h80) begin
      bad++; $display("FAIL rstmid_alone got=%0d/%h exp=1/80", count, pending_mask);
    end
    @(negedge clk);
    #1;
    total++; if (empty !== 1'b1 || rf_write_enable !== 1'b0) begin
      bad++; $display("FAIL rstmid_end got=%b/%b exp=1/0", empty, rf_write_enable);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_reg0();
    test_reset_mid();
    @(negedge clk);
    #3;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
